// File: rtl/branch_predictor_bht.sv
// Branch history table: ENTRIES saturating CTR_W-bit counters indexed by PC[IDX_W+1:2].
// Combinational lookup with target add; registered update on resolve; saturating perf counters.
module branch_predictor_bht #(
  parameter int ENTRIES  = 64,
  parameter int CTR_W    = 2,
  parameter int INIT_CTR = 1,
  parameter int PERF_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       in_addr,
  input  logic [31:0]       offset,
  input  logic              branch_decode_sig,
  output logic [31:0]       branch_addr,
  output logic              prediction,
  input  logic              branch_mem_sig,
  input  logic [31:0]       update_addr,
  input  logic              actual_branch_decision,
  input  logic              mistake,
  input  logic              clear,
  output logic [PERF_W-1:0] branch_cnt,
  output logic [PERF_W-1:0] mispredict_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] INIT = CTR_W'(INIT_CTR);

  logic [CTR_W-1:0] tbl [ENTRIES];
  logic [IDX_W-1:0] ridx;
  logic [IDX_W-1:0] widx;
  logic             unused_addr_bits;

  assign ridx = in_addr[IDX_W+1:2];
  assign widx = update_addr[IDX_W+1:2];
  // High PC bits are intentionally dropped, so aliasing branches share an entry.
  assign unused_addr_bits = ^{update_addr[31:IDX_W+2], update_addr[1:0]};

  assign branch_addr = in_addr + offset;
  assign prediction  = branch_decode_sig & tbl[ridx][CTR_W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) tbl[i] <= INIT;
    end else if (clear) begin
      for (int unsigned i = 0; i < ENTRIES; i++) tbl[i] <= INIT;
    end else if (branch_mem_sig) begin
      if (actual_branch_decision) begin
        if (tbl[widx] != '1) tbl[widx] <= tbl[widx] + CTR_W'(1);
      end else begin
        if (tbl[widx] != '0) tbl[widx] <= tbl[widx] - CTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else if (branch_mem_sig) begin
      if (branch_cnt != '1) branch_cnt <= branch_cnt + PERF_W'(1);
      if (mistake && mispredict_cnt != '1) mispredict_cnt <= mispredict_cnt + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Scoreboard bench for branch_predictor_bht: a wide-counter and a 4-bit-counter instance share stimulus.
module tb_branch_predictor_bht;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_addr = '0, offset = '0, update_addr = '0;
  logic        branch_decode_sig = 1'b0, branch_mem_sig = 1'b0;
  logic        actual_branch_decision = 1'b0, mistake = 1'b0, clear = 1'b0;
  logic [31:0] branch_addr, branch_addr4;
  logic        prediction, prediction4;
  logic [31:0] branch_cnt, mispredict_cnt;
  logic [3:0]  branch_cnt4, mispredict_cnt4;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  branch_predictor_bht dut (
    .clk(clk), .rst(rst), .in_addr(in_addr), .offset(offset),
    .branch_decode_sig(branch_decode_sig), .branch_addr(branch_addr), .prediction(prediction),
    .branch_mem_sig(branch_mem_sig), .update_addr(update_addr),
    .actual_branch_decision(actual_branch_decision), .mistake(mistake), .clear(clear),
    .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  branch_predictor_bht #(.PERF_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_addr(in_addr), .offset(offset),
    .branch_decode_sig(branch_decode_sig), .branch_addr(branch_addr4), .prediction(prediction4),
    .branch_mem_sig(branch_mem_sig), .update_addr(update_addr),
    .actual_branch_decision(actual_branch_decision), .mistake(mistake), .clear(clear),
    .branch_cnt(branch_cnt4), .mispredict_cnt(mispredict_cnt4)
  );

  // Reference model: 64 two-bit counters, init 1, perf counters at 32 and 4 bits.
  int          m_ctr [64];
  longint      m_b32, m_m32;
  int          m_b4, m_m4;

  typedef struct {
    int          kind;
    logic [31:0] val;
  } exp_t;
  exp_t sbq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_ctr[i] = 1;
    m_b32 = 0; m_m32 = 0; m_b4 = 0; m_m4 = 0;
  endtask

  function automatic int midx(input logic [31:0] a);
    return int'((a >> 2) & 32'd63);
  endfunction

  function automatic logic [31:0] observed(input int kind);
    case (kind)
      0: return {31'd0, prediction};
      1: return branch_addr;
      2: return branch_cnt;
      3: return mispredict_cnt;
      4: return {28'd0, branch_cnt4};
      5: return {28'd0, mispredict_cnt4};
      6: return {31'd0, prediction4};
      default: return branch_addr4;
    endcase
  endfunction

  // One cycle: drive after the rising edge, score at the falling edge, then advance the model.
  task automatic cyc(input logic [31:0] la, input logic [31:0] off, input logic dec,
                     input logic mem, input logic [31:0] ua, input logic tk,
                     input logic mis, input logic clr, input logic r);
    string names [8] = '{"pred", "addr", "bcnt", "mcnt", "bcnt4", "mcnt4", "pred4", "addr4"};
    logic  p;
    @(posedge clk);
    #1;
    in_addr = la; offset = off; branch_decode_sig = dec;
    branch_mem_sig = mem; update_addr = ua; actual_branch_decision = tk;
    mistake = mis; clear = clr; rst = r;
    if (r) model_reset();
    p = dec && (m_ctr[midx(la)] >= 2);
    sbq.push_back('{0, {31'd0, p}});
    sbq.push_back('{1, la + off});
    sbq.push_back('{2, m_b32[31:0]});
    sbq.push_back('{3, m_m32[31:0]});
    sbq.push_back('{4, 32'(m_b4)});
    sbq.push_back('{5, 32'(m_m4)});
    sbq.push_back('{6, {31'd0, p}});
    sbq.push_back('{7, la + off});
    @(negedge clk);
    while (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      check(names[e.kind], observed(e.kind), e.val);
    end
    if (!r) begin
      if (clr) begin
        for (int i = 0; i < 64; i++) m_ctr[i] = 1;
      end else if (mem) begin
        if (tk && m_ctr[midx(ua)] < 3) m_ctr[midx(ua)]++;
        if (!tk && m_ctr[midx(ua)] > 0) m_ctr[midx(ua)]--;
      end
      if (mem) begin
        if (m_b32 < 64'hFFFF_FFFF) m_b32++;
        if (m_b4 < 15) m_b4++;
        if (mis) begin
          if (m_m32 < 64'hFFFF_FFFF) m_m32++;
          if (m_m4 < 15) m_m4++;
        end
      end
    end
  endtask

  task automatic look(input logic [31:0] la);
    cyc(la, 32'h10, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic upd(input logic [31:0] ua, input logic tk);
    cyc(32'h0, 32'h0, 1'b0, 1'b1, ua, tk, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    // reset pulse then first lookup
    cyc(32'h40, 32'h10, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(32'h40, 32'h10, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    look(32'h40);
    check("t1_pred", {31'd0, prediction}, 32'd0);
    check("t1_addr", branch_addr, 32'h50);
    // wrapping target add, and branch_addr driven without branch_decode_sig
    cyc(32'hFFFF_FFF0, 32'h20, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("wrap_addr", branch_addr, 32'h10);
    cyc(32'h100, 32'hFFFF_FFF8, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

    // two taken updates, alias and neighbour lookups
    upd(32'h40, 1'b1);
    upd(32'h40, 1'b1);
    look(32'h40);
    check("t2_pred", {31'd0, prediction}, 32'd1);
    look(32'h140);
    check("t2_alias", {31'd0, prediction}, 32'd1);
    look(32'h44);
    check("t2_neigh", {31'd0, prediction}, 32'd0);
    cyc(32'h40, 32'h0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

    // saturation high and low at 0x80
    for (int i = 0; i < 5; i++) upd(32'h80, 1'b1);
    upd(32'h80, 1'b0);
    look(32'h80);
    check("t3_sat_hi", {31'd0, prediction}, 32'd1);
    upd(32'h80, 1'b0);
    look(32'h80);
    check("t3_down", {31'd0, prediction}, 32'd0);
    for (int i = 0; i < 4; i++) upd(32'h80, 1'b0);
    upd(32'h80, 1'b1);
    look(32'h80);
    check("t3_sat_lo", {31'd0, prediction}, 32'd0);
    upd(32'h80, 1'b1);
    look(32'h80);

    // clear, then same-cycle lookup and taken update at 0x40 (counter 1)
    cyc(32'h0, 32'h0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(32'h40, 32'h10, 1'b1, 1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t4_same", {31'd0, prediction}, 32'd0);
    look(32'h40);
    check("t4_next", {31'd0, prediction}, 32'd1);

    // clear beats a simultaneous taken update; perf counter still counts
    upd(32'h80, 1'b1);
    cyc(32'h0, 32'h0, 1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 1'b1, 1'b0);
    look(32'h40);
    look(32'h80);
    look(32'h140);

    // jump-style mistake without branch_mem_sig is not counted
    cyc(32'h0, 32'h0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);

    // perf saturation on the 4-bit instance
    cyc(32'h0, 32'h0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++)
      cyc(32'h0, 32'h0, 1'b0, 1'b1, 32'(i * 4), i[0], (i == 2 || i == 9 || i == 17), 1'b0, 1'b0);
    look(32'h0);
    check("t6_bcnt4", {28'd0, branch_cnt4}, 32'd15);
    check("t6_mcnt4", {28'd0, mispredict_cnt4}, 32'd3);
    check("t6_bcnt32", branch_cnt, 32'd20);
    // reset mid-stream with an update in flight
    cyc(32'h0, 32'h0, 1'b0, 1'b1, 32'h40, 1'b1, 1'b1, 1'b0, 1'b1);
    check("t6_rst_b", {28'd0, branch_cnt4}, 32'd0);
    check("t6_rst_m", {28'd0, mispredict_cnt4}, 32'd0);
    upd(32'h40, 1'b1);
    look(32'h40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
